// File: rtl/rot_pkg.sv
// Shared types for the sequential rotate engine: FSM state encoding and default width.
package rot_pkg;

  localparam int DEFAULT_DATA_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rot_step.sv
// Combinational single-position rotate; dir=0 rotates right, dir=1 rotates left.
module rot_step #(
  parameter int DATA_WIDTH = 20
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  dir_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    if (dir_i) data_o = {data_i[DATA_WIDTH-2:0], data_i[DATA_WIDTH-1]};
    else       data_o = {data_i[0], data_i[DATA_WIDTH-1:1]};
  end

endmodule

// File: rtl/rotright_seq.sv
// Multi-cycle rotate engine, one bit position per clock, start/busy/done handshake.
// Define ROTRIGHT_BIDIR_EN to add the dir input (0=right, 1=left).
//
// state | meaning
// IDLE  | waiting for start; data_out holds the last result
// SHIFT | rotating one position per clock, cnt counts down remaining steps
// DONE  | one-cycle done pulse, then back to IDLE regardless of start
module rotright_seq
  import rot_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] shift_amount,
`ifdef ROTRIGHT_BIDIR_EN
  input  logic                  dir,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [DATA_WIDTH-1:0] DW_L = DATA_WIDTH'(DATA_WIDTH);

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    busy_q;
  logic                    done_q;
  logic                    dir_q;
  logic [CNT_WIDTH-1:0]    k_d;

  // Full-width unsigned modulo so amounts >= DATA_WIDTH wrap.
  assign k_d = CNT_WIDTH'(shift_amount % DW_L);

`ifdef ROTRIGHT_BIDIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         dir_q <= 1'b0;
    else if (state_q == IDLE && start)  dir_q <= dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  rot_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .data_i (data_q),
    .dir_i  (dir_q),
    .data_o (data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            data_q <= data_in;
            cnt_q  <= k_d;
            busy_q <= 1'b1;
            if (k_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_rotright_seq.sv
// Directed bench for rotright_seq: latency, wrap, start-while-busy and mid-run reset.
module tb_rotright_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] data_in;
  logic [19:0] shift_amount;
  logic        dir_s;
  logic        busy;
  logic        done;
  logic [19:0] data_out;

  int checks = 0;
  int errors = 0;

  rotright_seq u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data_in      (data_in),
    .shift_amount (shift_amount),
`ifdef ROTRIGHT_BIDIR_EN
    .dir          (dir_s),
`endif
    .busy         (busy),
    .done         (done),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run; cycle c=1 is the cycle after the capture edge E0.
  task automatic run(input string tag, input logic [19:0] d, input logic [19:0] amt,
                     input logic dr, input logic [19:0] exp_res, input int k);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    data_in = d; shift_amount = amt; dir_s = dr; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= k + 3; c++) begin
      @(negedge clk);
      if (c == 1) check_val({tag, "_capture"}, 32'(data_out), 32'(d));
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
    end
    check_val({tag, "_done_cycle"}, 32'(done_at), 32'(k + 1));
    check_val({tag, "_done_count"}, 32'(done_n), 32'd1);
    check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(k + 1));
    check_val({tag, "_result"}, 32'(data_out), 32'(exp_res));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; data_in = '0; shift_amount = '0; dir_s = 1'b0;
    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_data", 32'(data_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run("k4",  20'hEC880, 20'd4,  1'b0, 20'h0EC88, 4);
    run("k23", 20'hEC880, 20'd23, 1'b0, 20'h1D910, 3);
    run("k20", 20'hEC880, 20'd20, 1'b0, 20'hEC880, 0);
    run("k1",  20'h00001, 20'd1,  1'b0, 20'h80000, 1);
    run("k19", 20'h00001, 20'd19, 1'b0, 20'h00002, 19);

    // start held high across the whole run; data_in changes mid-run must be ignored
    @(negedge clk);
    data_in = 20'hEC880; shift_amount = 20'd8; start = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_val("hold_capture", 32'(data_out), 32'h0EC880);
        data_in = 20'h12345;
      end
      if (done) seen = c;
      if (c == 10) begin
        check_val("hold_idle_busy", 32'(busy), 32'd0);
        check_val("hold_result", 32'(data_out), 32'h080EC8);
      end
      if (c == 11) begin
        check_val("hold_recapture_busy", 32'(busy), 32'd1);
        check_val("hold_recapture_data", 32'(data_out), 32'h012345);
      end
    end
    check_val("hold_done_cycle", 32'(seen), 32'd9);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check_val("hold_second_done", 32'(seen), 32'd1);
    check_val("hold_second_result", 32'(data_out), 32'h045123);
    @(negedge clk);

    // asynchronous reset in cycle 2 of a k=8 run
    @(negedge clk);
    data_in = 20'hEC880; shift_amount = 20'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_data", 32'(data_out), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check_val("midrst_quiet", 32'(seen), 32'd0);
    run("after_rst", 20'hEC880, 20'd4, 1'b0, 20'h0EC88, 4);

`ifdef ROTRIGHT_BIDIR_EN
    run("left4",  20'hEC880, 20'd4, 1'b1, 20'hC880E, 4);
    run("right4", 20'hEC880, 20'd4, 1'b0, 20'h0EC88, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
